// File: rtl/unsign_div_bcd_serializer.sv
// Accepts one Quotient/Remainder pair, converts both to BCD with a sequential
// double-dabble engine, then emits decimal digits MS-first, quotient before remainder.
module unsign_div_bcd_serializer #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int DIGITS          = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INPUT_BIT_WIDTH-1:0] Quotient,
    input  logic [INPUT_BIT_WIDTH-1:0] Remainder,
    output logic                       DigitValid,
    input  logic                       DigitReady,
    output logic [3:0]                 Digit,
    output logic                       DigitIsRemainder,
    output logic                       DigitLast,
    output logic                       Busy
);

    localparam int CW = $clog2(INPUT_BIT_WIDTH + 1);
    localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT_Q,
        EMIT_R
    } state_t;

    state_t state, state_next;

    logic [INPUT_BIT_WIDTH-1:0] q_bin, r_bin;
    logic [BW-1:0]              q_bcd, r_bcd;
    logic [BW-1:0]              q_shift, r_shift;
    logic [CW-1:0]              cnt;
    logic [PW-1:0]              ptr;
    logic                       conv_done;
    logic                       ptr_zero;

    // One double-dabble iteration: correct every nibble >= 5, then shift in the next bit.
    function automatic logic [BW-1:0] dabble(input logic [BW-1:0] bcd, input logic in_bit);
        logic [BW-1:0] adj;
        adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BW-2:0], in_bit};
    endfunction

    function automatic logic [PW-1:0] top_digit(input logic [BW-1:0] bcd);
        logic [PW-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) p = PW'(i);
        end
        return p;
    endfunction

    assign q_shift   = dabble(q_bcd, q_bin[INPUT_BIT_WIDTH-1]);
    assign r_shift   = dabble(r_bcd, r_bin[INPUT_BIT_WIDTH-1]);
    assign conv_done = (cnt == CW'(INPUT_BIT_WIDTH - 1));
    assign ptr_zero  = (ptr == '0);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (InValid) state_next = CONV;
            CONV:    if (conv_done) state_next = EMIT_Q;
            EMIT_Q:  if (DigitReady && ptr_zero) state_next = EMIT_R;
            EMIT_R:  if (DigitReady && ptr_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_bin <= '0;
            r_bin <= '0;
            q_bcd <= '0;
            r_bcd <= '0;
            cnt   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        q_bin <= Quotient;
                        r_bin <= Remainder;
                        q_bcd <= '0;
                        r_bcd <= '0;
                        cnt   <= '0;
                    end
                end
                CONV: begin
                    q_bin <= q_bin << 1;
                    r_bin <= r_bin << 1;
                    q_bcd <= q_shift;
                    r_bcd <= r_shift;
                    cnt   <= cnt + 1'b1;
                    // Pointer is seeded from the post-shift value so EMIT_Q starts on its MS digit.
                    if (conv_done) ptr <= top_digit(q_shift);
                end
                EMIT_Q: begin
                    if (DigitReady) begin
                        if (ptr_zero) ptr <= top_digit(r_bcd);
                        else          ptr <= ptr - 1'b1;
                    end
                end
                EMIT_R: begin
                    if (DigitReady && !ptr_zero) ptr <= ptr - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Digit = '0;
        case (state)
            EMIT_Q:  Digit = q_bcd[{ptr, 2'b00} +: 4];
            EMIT_R:  Digit = r_bcd[{ptr, 2'b00} +: 4];
            default: Digit = '0;
        endcase
    end

    assign InReady          = (state == IDLE);
    assign Busy             = (state != IDLE);
    assign DigitValid       = (state == EMIT_Q) || (state == EMIT_R);
    assign DigitIsRemainder = (state == EMIT_R);
    assign DigitLast        = (state == EMIT_R) && ptr_zero;

endmodule

// File: tb/tb_unsign_div_bcd_serializer.sv
// Self-checking bench: directed cases plus random pairs, each compared against a
// decimal-string model of the expected digit stream.
module tb_unsign_div_bcd_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         digit_valid;
    logic         digit_ready;
    logic [3:0]   digit;
    logic         digit_is_rem;
    logic         digit_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_d[$];
    bit exp_r[$];
    bit exp_l[$];

    always #5 clk = ~clk;

    unsign_div_bcd_serializer #(
        .INPUT_BIT_WIDTH(W),
        .DIGITS         (3)
    ) dut (
        .Clk             (clk),
        .Reset           (reset),
        .InValid         (in_valid),
        .InReady         (in_ready),
        .Quotient        (quotient),
        .Remainder       (remainder),
        .DigitValid      (digit_valid),
        .DigitReady      (digit_ready),
        .Digit           (digit),
        .DigitIsRemainder(digit_is_rem),
        .DigitLast       (digit_last),
        .Busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Decimal digits of v, most significant first; zero is a single '0'.
    task automatic push_value(input int v, input bit is_rem);
        int tmp[$];
        tmp = {};
        if (v == 0) tmp.push_back(0);
        while (v > 0) begin
            tmp.push_front(v % 10);
            v = v / 10;
        end
        foreach (tmp[i]) begin
            exp_d.push_back(tmp[i]);
            exp_r.push_back(is_rem);
            exp_l.push_back(is_rem && (i == tmp.size() - 1));
        end
    endtask

    task automatic accept_pair(input int q, input int r);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        quotient  = W'(q);
        remainder = W'(r);
        step();
        in_valid  = 1'b0;
        quotient  = W'($urandom);
        remainder = W'($urandom);
    endtask

    task automatic run_pair(input int q, input int r, input bit stall_first,
                            input bit rand_ready, input bit inject);
        int cyc, idx, guard, stalls;
        exp_d = {};
        exp_r = {};
        exp_l = {};
        push_value(q, 1'b0);
        push_value(r, 1'b1);
        accept_pair(q, r);

        cyc = 0;
        while (!digit_valid && cyc < 50) begin
            check("busy_in_conv", busy, 1);
            check("in_ready_in_conv", in_ready, 0);
            if (inject) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                quotient  = 8'd9;
                remainder = 8'd9;
            end
            step();
            cyc++;
        end
        check("first_digit_latency", cyc, W);

        idx    = 0;
        guard  = 0;
        stalls = 0;
        while (idx < exp_d.size() && guard < 200) begin
            check("digit_valid_no_gap", digit_valid, 1);
            if (digit_valid) begin
                check("digit", digit, exp_d[idx]);
                check("digit_is_rem", digit_is_rem, exp_r[idx]);
                check("digit_last", digit_last, exp_l[idx]);
                check("in_ready_in_emit", in_ready, 0);
            end
            if (stall_first && idx == 0 && stalls < 5) begin
                digit_ready = 1'b0;
                stalls++;
            end else if (rand_ready) begin
                digit_ready = ($urandom_range(0, 3) != 0);
            end else begin
                digit_ready = 1'b1;
            end
            if (digit_ready && digit_valid) idx++;
            if (inject) begin
                in_valid  = ($urandom_range(0, 1) == 1);
                quotient  = 8'd9;
                remainder = 8'd9;
            end
            step();
            guard++;
        end
        check("emission_within_budget", (guard < 200), 1);
        in_valid    = 1'b0;
        digit_ready = $urandom_range(0, 1);
        check("idle_after_last_valid", digit_valid, 0);
        check("idle_after_last_ready", in_ready, 1);
        check("idle_after_last_busy", busy, 0);
    endtask

    initial begin
        int guard;
        reset       = 1'b1;
        in_valid    = 1'b0;
        quotient    = '0;
        remainder   = '0;
        digit_ready = 1'b0;
        step();
        step();
        check("reset_in_ready", in_ready, 1);
        check("reset_digit_valid", digit_valid, 0);
        check("reset_digit", digit, 0);
        check("reset_is_rem", digit_is_rem, 0);
        check("reset_last", digit_last, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        step();

        run_pair(6, 1, 1'b0, 1'b0, 1'b0);
        run_pair(255, 0, 1'b0, 1'b0, 1'b0);
        run_pair(0, 0, 1'b0, 1'b0, 1'b0);
        run_pair(100, 7, 1'b0, 1'b0, 1'b0);
        run_pair(42, 3, 1'b1, 1'b0, 1'b0);
        run_pair(12, 1, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of emitting the quotient of 123.
        accept_pair(123, 45);
        guard = 0;
        while (!digit_valid && guard < 50) begin
            step();
            guard++;
        end
        check("reset_case_digit0", digit, 1);
        digit_ready = 1'b1;
        step();
        check("reset_case_digit1", digit, 2);
        reset = 1'b1;
        step();
        check("mid_reset_digit_valid", digit_valid, 0);
        check("mid_reset_in_ready", in_ready, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_last", digit_last, 0);
        reset       = 1'b0;
        digit_ready = 1'b0;
        step();
        run_pair(5, 2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            run_pair($urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b1,
                     ($urandom_range(0, 1) == 1));
        end
        run_pair(9, 255, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
